// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, counter width and index-width helper for the BIST sequencer
package bist_pkg;
  typedef enum logic [2:0] {IDLE, RELEASE, RUN, RECORD, DONE} bist_seq_state_t;
  localparam int BIST_CNT_W = 32;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bist_sequencer_if.sv
// bist_sequencer_if: test/config + per-link BIST signals; master = test side and links, slave = sequencer
interface bist_sequencer_if import bist_pkg::*; #(parameter int NUM_LINKS = 4);
  localparam int IW = idx_w(NUM_LINKS);
  logic start;
  logic [NUM_LINKS-1:0] link_busy, link_failed, link_reset, fail_mask, timeout_mask;
  logic active, done, pass;
  logic [IW-1:0] cur_link;
  modport master (output start, link_busy, link_failed,
                  input link_reset, active, cur_link, done, pass, fail_mask, timeout_mask);
  modport slave (input start, link_busy, link_failed,
                 output link_reset, active, cur_link, done, pass, fail_mask, timeout_mask);
endinterface

// File: rtl/bist_link_timer.sv
// bist_link_timer: saturating per-link cycle counter with settle/timeout compares
// ports: clk, reset (async), clr (load 0, wins over en), en (count), settle_hit, timeout_hit
module bist_link_timer import bist_pkg::*; #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic reset,
  input logic clr,
  input logic en,
  output logic settle_hit,
  output logic timeout_hit
);
  logic [BIST_CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && ~&cnt) cnt <= cnt + BIST_CNT_W'(1);
  assign settle_hit = cnt == BIST_CNT_W'(SETTLE_CYCLES - 1);
  assign timeout_hit = cnt == BIST_CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/bist_sequencer.sv
// bist_sequencer: releases BIST links one at a time and records per-link pass/fail/timeout
// ports: clk, reset (async, active-high), bus (slave side of bist_sequencer_if)
module bist_sequencer import bist_pkg::*; #(
  parameter int NUM_LINKS = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic reset,
  bist_sequencer_if.slave bus
);
  localparam int IW = idx_w(NUM_LINKS);
  bist_seq_state_t state, state_n;
  logic [NUM_LINKS-1:0] lr, lr_n, fm, fm_n, tm, tm_n, sel;
  logic [IW-1:0] cl, cl_n;
  logic act, act_n, dn, dn_n, ps, ps_n, clr, en, settle_hit, timeout_hit, last;
  assign sel = NUM_LINKS'(1) << cl;
  assign last = cl == IW'(NUM_LINKS - 1);
  bist_link_timer #(.SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .settle_hit(settle_hit), .timeout_hit(timeout_hit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lr <= '1;
      fm <= '0;
      tm <= '0;
      cl <= '0;
      act <= 1'b0;
      dn <= 1'b0;
      ps <= 1'b0;
    end else begin
      state <= state_n;
      lr <= lr_n;
      fm <= fm_n;
      tm <= tm_n;
      cl <= cl_n;
      act <= act_n;
      dn <= dn_n;
      ps <= ps_n;
    end
  // outputs are registered, so the link under test is released on the edge that enters RELEASE
  always_comb begin
    state_n = state;
    lr_n = lr;
    fm_n = fm;
    tm_n = tm;
    cl_n = cl;
    act_n = act;
    dn_n = dn;
    ps_n = ps;
    clr = 1'b0;
    en = 1'b0;
    case (state)
      IDLE, DONE: if (bus.start) begin
        state_n = RELEASE;
        lr_n = ~NUM_LINKS'(1);
        fm_n = '0;
        tm_n = '0;
        cl_n = '0;
        act_n = 1'b1;
        dn_n = 1'b0;
        ps_n = 1'b0;
        clr = 1'b1;
      end
      RELEASE: begin
        en = 1'b1;
        state_n = settle_hit ? RUN : RELEASE;
      end
      RUN: begin
        en = 1'b1;
        // busy-low takes priority over a coincident timeout
        if (!bus.link_busy[cl]) state_n = RECORD;
        else if (timeout_hit) begin
          state_n = RECORD;
          tm_n = tm | sel;
          lr_n = lr | sel;
        end
      end
      RECORD: begin
        fm_n[cl] = tm[cl] ? fm[cl] : bus.link_failed[cl];
        if (last) begin
          state_n = DONE;
          act_n = 1'b0;
          dn_n = 1'b1;
          ps_n = ~|(fm_n | tm);
        end else begin
          state_n = RELEASE;
          cl_n = cl + IW'(1);
          lr_n = lr & ~(sel << 1);
          clr = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.link_reset = lr;
  assign bus.fail_mask = fm;
  assign bus.timeout_mask = tm;
  assign bus.cur_link = cl;
  assign bus.active = act;
  assign bus.done = dn;
  assign bus.pass = ps;
endmodule
